// File: rtl/led_panel_receiver.sv
// led_panel_receiver
//   Recovers per-channel 8-bit duty values from a serial LED driver stream.
//   A 16-bit shift register collects one PWM slot pattern per load. A frame
//   is 256 slots, and its first slot is tagged by frame_start. Each channel
//   counts the slots in which it was on. When the next frame_start arrives
//   after exactly 256 slots, the counts are published as component_values.
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   serial_data_in    serial bit, accepted when shift is high (MSB first)
//   shift             shift enable
//   load_led_vals     latch sr into led_state and advance the slot accumulator
//   load_brightness   latch sr[7:0] into brightness
//   frame_start       marks the load_led_vals pulse of slot 0
//   led_state         last latched slot pattern (bit i = channel i)
//   brightness        last latched brightness byte
//   component_values  channel i duty at [8i+7:8i]
//   frame_valid       1-cycle pulse when component_values updates
//   frame_error       1-cycle pulse on short frame, overrun or saturated channel

// Per-channel on-slot counter. restart wins over accum.
module led_chan_acc (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       accum,
  input  logic       din,
  output logic [8:0] on_cnt
);
  always_ff @(posedge clk) begin
    if (reset)        on_cnt <= 9'd0;
    else if (restart) on_cnt <= {8'd0, din};
    else if (accum)   on_cnt <= on_cnt + {8'd0, din};
  end
endmodule

module led_panel_receiver (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_data_in,
  input  logic         shift,
  input  logic         load_led_vals,
  input  logic         load_brightness,
  input  logic         frame_start,
  output logic [15:0]  led_state,
  output logic [7:0]   brightness,
  output logic [127:0] component_values,
  output logic         frame_valid,
  output logic         frame_error
);
  localparam int NUM_LANES = 16;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                        state, state_nxt;
  logic [15:0]                   sr;
  logic [8:0]                    slot_cnt;
  logic [NUM_LANES-1:0][8:0]     on_cnt;
  logic [NUM_LANES-1:0][7:0]     duty;
  logic [NUM_LANES-1:0][7:0]     comp_q;
  logic [NUM_LANES-1:0]          sat;
  logic                          slot_full;
  logic                          restart, accum, publish, err_nxt;

  assign slot_full        = (slot_cnt == 9'd256);
  assign component_values = comp_q;

  // Loads sample sr before this cycle's shift, since both use the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr         <= '0;
      led_state  <= '0;
      brightness <= '0;
    end else begin
      if (shift)           sr         <= {sr[14:0], serial_data_in};
      if (load_led_vals)   led_state  <= sr;
      if (load_brightness) brightness <= sr[7:0];
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      led_chan_acc u_chan (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .accum   (accum),
        .din     (sr[g]),
        .on_cnt  (on_cnt[g])
      );
      // A channel that was on in all 256 slots reaches 256; clamp to 255.
      assign sat[g]  = on_cnt[g][8];
      assign duty[g] = sat[g] ? 8'hFF : on_cnt[g][7:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    accum     = 1'b0;
    publish   = 1'b0;
    err_nxt   = 1'b0;
    if (load_led_vals) begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            restart   = 1'b1;
            state_nxt = ACCUM;
          end
        end
        ACCUM: begin
          if (frame_start) begin
            // Every frame_start restarts counting; only a full frame publishes.
            restart = 1'b1;
            if (slot_full) publish = 1'b1;
            else           err_nxt = 1'b1;
          end else if (slot_full) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            accum = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt    <= '0;
      comp_q      <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (restart)    slot_cnt <= 9'd1;
      else if (accum) slot_cnt <= slot_cnt + 9'd1;
      if (publish)    comp_q   <= duty;
      frame_valid <= publish;
      frame_error <= err_nxt | (publish & (|sat));
    end
  end
endmodule
